// File: rtl/dram_responder_pkg.sv
// Shared widths, constants and state encoding for the DRAM data-port responder.
package dram_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int WEN_W  = 4;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_BUSY = 2'd1,
    RSP_RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/dram_responder_if.sv
// SRAM-like data port between the processor (master) and the memory responder (slave).
interface dram_responder_if;
  import dram_responder_pkg::*;

  // Handshake: the master raises dram_en with addr/wen/wdata and holds them
  // stable while dram_wait=1; the access completes in the first cycle where
  // dram_en=1 and dram_wait=0, and dram_rdata is valid only in that cycle.
  logic              dram_en;
  logic [WEN_W-1:0]  dram_wen;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata;
  logic [DATA_W-1:0] dram_rdata;
  logic              dram_wait;

  modport master (
    output dram_en, dram_wen, dram_addr, dram_wdata,
    input  dram_rdata, dram_wait
  );

  modport slave (
    input  dram_en, dram_wen, dram_addr, dram_wdata,
    output dram_rdata, dram_wait
  );

endinterface

// File: rtl/dram_store.sv
// Single-port word store: synchronous read, per-byte-lane write, no reset on contents.
module dram_store
  import dram_responder_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              ce,
  input  logic [WEN_W-1:0]  wen,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**IDX_W];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the pre-write contents; the responder only exposes it on reads.
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < WEN_W; i++) begin
        if (wen[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder: one word access at a time with a fixed number of wait states,
// plus a sticky flag for requests that change while being stalled.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int IDX_W   = 10,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  dram_responder_if.slave  bus,
  output logic             busy,
  output logic             proto_err,
  output rsp_state_e       dbg_state
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("dram_responder: LATENCY must be in 1..15");
  end

  rsp_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d, cnt_dec;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WEN_W-1:0]  wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              st_ce;
  logic [WEN_W-1:0]  st_wen;
  logic [IDX_W-1:0]  st_idx;
  logic [DATA_W-1:0] st_wdata, st_rdata;
  logic              wait_c;
  logic              req_changed;

  assign cnt_dec     = cnt_q - 4'd1;
  assign req_changed = (bus.dram_addr  != addr_q) ||
                       (bus.dram_wen   != wen_q)  ||
                       (bus.dram_wdata != wdata_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    st_ce    = 1'b0;
    st_wen   = wen_q;
    st_idx   = addr_q[IDX_W+1:2];
    st_wdata = wdata_q;
    wait_c   = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        wait_c = bus.dram_en;
        if (bus.dram_en) begin
          addr_d  = bus.dram_addr;
          wen_d   = bus.dram_wen;
          wdata_d = bus.dram_wdata;
          cnt_d   = 4'(LATENCY - 1);
          // With a single wait state the latch is not loaded yet, so the
          // store is driven straight from the bus on the accepting edge.
          if (LATENCY == 1) begin
            st_ce    = 1'b1;
            st_wen   = bus.dram_wen;
            st_idx   = bus.dram_addr[IDX_W+1:2];
            st_wdata = bus.dram_wdata;
            state_d  = RSP_RESP;
          end else begin
            state_d  = RSP_BUSY;
          end
        end
      end
      RSP_BUSY: begin
        wait_c = 1'b1;
        if (!bus.dram_en) begin
          cnt_d   = 4'd0;
          state_d = RSP_IDLE;
        end else begin
          if (req_changed) err_d = 1'b1;
          cnt_d = cnt_dec;
          if (cnt_dec == 4'd0) begin
            st_ce   = 1'b1;
            state_d = RSP_RESP;
          end
        end
      end
      RSP_RESP: begin
        state_d = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RSP_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  dram_store #(.IDX_W(IDX_W)) u_store (
    .clk   (clk),
    .ce    (st_ce),
    .wen   (st_wen),
    .idx   (st_idx),
    .wdata (st_wdata),
    .rdata (st_rdata)
  );

  // Read data is only exposed in the response cycle of a read; zero otherwise.
  assign bus.dram_rdata = (state_q == RSP_RESP && wen_q == '0) ? st_rdata : ZERO_WORD;
  assign bus.dram_wait  = wait_c;
  assign busy           = (state_q != RSP_IDLE);
  assign proto_err      = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: one instance with LATENCY=3, one with LATENCY=1.
module tb_dram_responder;
  import dram_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  dram_responder_if bus3 ();
  dram_responder_if bus1 ();

  logic       busy3, err3, busy1, err1;
  rsp_state_e st3, st1;

  dram_responder #(.IDX_W(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3), .proto_err(err3), .dbg_state(st3)
  );

  dram_responder #(.IDX_W(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .proto_err(err1), .dbg_state(st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle3();
    bus3.dram_en = 1'b0; bus3.dram_wen = 4'h0; bus3.dram_addr = 32'h0; bus3.dram_wdata = 32'h0;
  endtask

  // One complete access on the LATENCY=3 port; returns stall count, response data
  // and the data seen in the cycle after the response.
  task automatic do_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           output int waits, output logic [31:0] rd_resp,
                           output logic [31:0] rd_after);
    @(posedge clk); #1;
    bus3.dram_en = 1'b1; bus3.dram_addr = a; bus3.dram_wen = w; bus3.dram_wdata = d;
    waits = 0; rd_resp = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus3.dram_wait) waits++;
      else begin rd_resp = bus3.dram_rdata; break; end
    end
    @(posedge clk); #1;
    idle3();
    @(negedge clk);
    rd_after = bus3.dram_rdata;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus3.dram_wait !== 1'b0) begin n_fail++; $display("FAIL reset_wait: got %b expected 0", bus3.dram_wait); end
    n_tests++; if (bus3.dram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", bus3.dram_rdata); end
    n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy3); end
    n_tests++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", err3); end
    n_tests++; if (st3 !== RSP_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", st3); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    int w; logic [31:0] r, ra;
    do_access(32'h10, 4'hF, 32'hDEADBEEF, w, r, ra);
    n_tests++; if (w !== 3) begin n_fail++; $display("FAIL wr_waits: got %0d expected 3", w); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL wr_resp_rdata: got %h expected 00000000", r); end
    do_access(32'h10, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (w !== 3) begin n_fail++; $display("FAIL rd_waits: got %0d expected 3", w); end
    n_tests++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", r); end
    n_tests++; if (ra !== 32'h0) begin n_fail++; $display("FAIL rd_after_resp: got %h expected 00000000", ra); end
    n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rd_idle_busy: got %b expected 0", busy3); end
  endtask

  task automatic test_byte_lanes();
    int w; logic [31:0] r, ra;
    do_access(32'h20, 4'hF, 32'h11223344, w, r, ra);
    do_access(32'h20, 4'b0101, 32'hAABBCCDD, w, r, ra);
    do_access(32'h20, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'h11BB33DD) begin n_fail++; $display("FAIL byte_lanes: got %h expected 11bb33dd", r); end
  endtask

  task automatic test_aliasing();
    int w; logic [31:0] r, ra;
    do_access(32'h00001004, 4'hF, 32'hCAFEF00D, w, r, ra);
    do_access(32'h00000004, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_0x4: got %h expected cafef00d", r); end
    do_access(32'h00000007, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_0x7: got %h expected cafef00d", r); end
  endtask

  task automatic test_abort();
    int w; logic [31:0] r, ra;
    do_access(32'h40, 4'hF, 32'h0, w, r, ra);
    @(posedge clk); #1;
    bus3.dram_en = 1'b1; bus3.dram_addr = 32'h40; bus3.dram_wen = 4'hF; bus3.dram_wdata = 32'h55;
    @(posedge clk); #1;
    idle3();
    @(negedge clk);
    n_tests++; if (st3 !== RSP_BUSY) begin n_fail++; $display("FAIL abort_busy_state: got %0d expected 1", st3); end
    @(negedge clk);
    n_tests++; if (st3 !== RSP_IDLE) begin n_fail++; $display("FAIL abort_idle_state: got %0d expected 0", st3); end
    n_tests++; if (bus3.dram_wait !== 1'b0) begin n_fail++; $display("FAIL abort_wait: got %b expected 0", bus3.dram_wait); end
    n_tests++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL abort_proto_err: got %b expected 0", err3); end
    do_access(32'h40, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL abort_no_write: got %h expected 00000000", r); end
  endtask

  task automatic test_proto_err_reset();
    int w; logic [31:0] r, ra; logic seen;
    do_access(32'h80, 4'hF, 32'hA5A50080, w, r, ra);
    do_access(32'h84, 4'hF, 32'h5A5A0084, w, r, ra);
    // Read 0x80, then move the address while stalled.
    @(posedge clk); #1;
    bus3.dram_en = 1'b1; bus3.dram_addr = 32'h80; bus3.dram_wen = 4'h0; bus3.dram_wdata = 32'h0;
    @(posedge clk); #1;
    bus3.dram_addr = 32'h84;
    seen = 1'b0; r = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus3.dram_wait) begin seen = 1'b1; r = bus3.dram_rdata; break; end
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL proto_timeout: got %b expected 1", seen); end
    n_tests++; if (r !== 32'hA5A50080) begin n_fail++; $display("FAIL proto_latched_addr: got %h expected a5a50080", r); end
    n_tests++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL proto_err_set: got %b expected 1", err3); end
    @(posedge clk); #1;
    idle3();
    do_access(32'h84, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'h5A5A0084) begin n_fail++; $display("FAIL proto_next_read: got %h expected 5a5a0084", r); end
    n_tests++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL proto_err_sticky: got %b expected 1", err3); end
    // Asynchronous reset in the response cycle of a read.
    @(posedge clk); #1;
    bus3.dram_en = 1'b1; bus3.dram_addr = 32'h10; bus3.dram_wen = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus3.dram_wait) begin seen = 1'b1; break; end
    end
    n_tests++; if (bus3.dram_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_rdata: got %h expected deadbeef", bus3.dram_rdata); end
    #1;
    rst = 1'b0;
    idle3();
    #1;
    n_tests++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL async_rst_proto_err: got %b expected 0", err3); end
    n_tests++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy3); end
    n_tests++; if (bus3.dram_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rst_rdata: got %h expected 00000000", bus3.dram_rdata); end
    n_tests++; if (bus3.dram_wait !== 1'b0) begin n_fail++; $display("FAIL async_rst_wait: got %b expected 0", bus3.dram_wait); end
    @(posedge clk); #1;
    rst = 1'b1;
    // Reset in the middle of a write must leave the word untouched.
    @(posedge clk); #1;
    bus3.dram_en = 1'b1; bus3.dram_addr = 32'h10; bus3.dram_wen = 4'hF; bus3.dram_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle3();
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(32'h10, 4'h0, 32'h0, w, r, ra);
    n_tests++; if (r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_mid_write: got %h expected deadbeef", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'h0BADF00D; words[1] = 32'h12345678;
    words[2] = 32'h80000001; words[3] = 32'hFFFF0000;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      bus1.dram_en    = 1'b1;
      bus1.dram_addr  = 32'h100 + 32'(4 * (k % 4));
      bus1.dram_wen   = (k < 4) ? 4'hF : 4'h0;
      bus1.dram_wdata = (k < 4) ? words[k] : 32'h0;
      @(negedge clk);
      n_tests++; if (bus1.dram_wait !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_hi[%0d]: got %b expected 1", k, bus1.dram_wait); end
      @(negedge clk);
      n_tests++; if (bus1.dram_wait !== 1'b0) begin n_fail++; $display("FAIL b2b_wait_lo[%0d]: got %b expected 0", k, bus1.dram_wait); end
      if (k >= 4) begin
        n_tests++; if (bus1.dram_rdata !== words[k-4]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, bus1.dram_rdata, words[k-4]); end
      end
    end
    @(posedge clk); #1;
    bus1.dram_en = 1'b0; bus1.dram_wen = 4'h0;
    @(negedge clk);
    n_tests++; if (st1 !== RSP_IDLE) begin n_fail++; $display("FAIL b2b_end_state: got %0d expected 0", st1); end
    n_tests++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL b2b_proto_err: got %b expected 0", err1); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    idle3();
    bus1.dram_en = 1'b0; bus1.dram_wen = 4'h0; bus1.dram_addr = 32'h0; bus1.dram_wdata = 32'h0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_aliasing();
    test_abort();
    test_proto_err_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
